// File: rtl/jtag_types_pkg.sv
// Shared types and constants for the generic-bus arbiter: FSM states,
// the one-hot grant encoding and the timeout response word.
package jtag_types_pkg;

  localparam int unsigned GBUS_AW = 32;
  localparam int unsigned GBUS_DW = 32;
  localparam int unsigned GBUS_BW = GBUS_DW / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DBG_XFER = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_CPU  = 2'b01,
    GRANT_DBG  = 2'b10
  } grant_e;

  // Returned to a requester whose transfer was abandoned by the timeout.
  localparam logic [GBUS_DW-1:0] DEAD_BEEF = 32'hDEAD_BEEF;

  function automatic grant_e state_to_grant(input arb_state_e state);
    case (state)
      CPU_XFER: return GRANT_CPU;
      DBG_XFER: return GRANT_DBG;
      default:  return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Generic single-beat bus: the requester drives address/data/strobes and
// the target answers with read data and a busy (wait) flag.
interface generic_bus_if;
  import jtag_types_pkg::*;

  logic [GBUS_AW-1:0] addr;
  logic [GBUS_DW-1:0] wdata;
  logic               ren;
  logic               wen;
  logic [GBUS_BW-1:0] byte_en;
  logic [GBUS_DW-1:0] rdata;
  logic               busy;

  // Target side: what a bus slave sees.
  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy
  );

  // Initiator side: what a bus master drives.
  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy
  );

endinterface

// File: rtl/xfer_timer.sv
// Saturating wait-cycle counter; flags expiry once LIMIT busy cycles were seen.
module xfer_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT_C);

endmodule

// File: rtl/gbus_arbiter.sv
// Two-requester arbiter (CPU and debug access point) onto one downstream
// generic bus, with debug grant locking and a downstream busy timeout.
module gbus_arbiter
  import jtag_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LOCK_MAX       = 16
) (
  input  logic                      AFT_CLK,
  input  logic                      RST,
  generic_bus_if.generic_bus        cpu_gbif,
  generic_bus_if.generic_bus        dbg_gbif,
  generic_bus_if.cpu                out_gbif,
  input  logic                      dbg_lock,
  output logic                      cpu_err,
  output logic                      dbg_err,
  output logic [1:0]                grant
);

  localparam int unsigned LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);

  arb_state_e    state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  logic cpu_req, dbg_req, granted_req;
  logic xfer_done, xfer_abort, timed_out;
  logic timer_en, timer_clr, timer_expired;

  assign cpu_req = cpu_gbif.ren | cpu_gbif.wen;
  assign dbg_req = dbg_gbif.ren | dbg_gbif.wen;

  always_comb begin
    granted_req = 1'b0;
    case (state_q)
      CPU_XFER: granted_req = cpu_req;
      DBG_XFER: granted_req = dbg_req;
      default:  granted_req = 1'b0;
    endcase
  end

  // Next-state, last-grant and lock bookkeeping.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    xfer_done    = 1'b0;
    xfer_abort   = 1'b0;
    timed_out    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req && dbg_req) begin
          state_d = (last_grant_q == GRANT_CPU) ? DBG_XFER : CPU_XFER;
        end else if (cpu_req) begin
          state_d = CPU_XFER;
        end else if (dbg_req) begin
          state_d = DBG_XFER;
        end
      end

      CPU_XFER: begin
        if (!cpu_req) begin
          xfer_abort = 1'b1;
          state_d    = IDLE;
        end else if (!out_gbif.busy) begin
          xfer_done    = 1'b1;
          last_grant_d = GRANT_CPU;
          state_d      = IDLE;
        end else if (timer_expired) begin
          timed_out    = 1'b1;
          last_grant_d = GRANT_CPU;
          state_d      = IDLE;
        end
      end

      DBG_XFER: begin
        // A locked debug port keeps the bus even between its requests.
        if (!dbg_req) begin
          if (!dbg_lock) begin
            xfer_abort = 1'b1;
            lock_cnt_d = '0;
            state_d    = IDLE;
          end
        end else if (!out_gbif.busy) begin
          xfer_done    = 1'b1;
          last_grant_d = GRANT_DBG;
          if (dbg_lock && (lock_cnt_q < LOCK_LAST)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_d = '0;
            state_d    = IDLE;
          end
        end else if (timer_expired) begin
          timed_out    = 1'b1;
          last_grant_d = GRANT_DBG;
          lock_cnt_d   = '0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AFT_CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DBG;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  assign timer_en  = granted_req & out_gbif.busy;
  assign timer_clr = (state_d != state_q) | xfer_done | xfer_abort;

  xfer_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_xfer_timer (
    .clk     (AFT_CLK),
    .rst     (RST),
    .en      (timer_en),
    .clr     (timer_clr),
    .expired (timer_expired)
  );

  // Bus steering: downstream strobes depend only on state and requester
  // inputs, never on downstream busy.
  always_comb begin
    out_gbif.addr    = '0;
    out_gbif.wdata   = '0;
    out_gbif.ren     = 1'b0;
    out_gbif.wen     = 1'b0;
    out_gbif.byte_en = '0;
    cpu_gbif.rdata   = '0;
    cpu_gbif.busy    = 1'b1;
    dbg_gbif.rdata   = '0;
    dbg_gbif.busy    = 1'b1;

    case (state_q)
      CPU_XFER: begin
        out_gbif.addr    = cpu_gbif.addr;
        out_gbif.wdata   = cpu_gbif.wdata;
        out_gbif.byte_en = cpu_gbif.byte_en;
        out_gbif.wen     = cpu_gbif.wen;
        out_gbif.ren     = cpu_gbif.ren & ~cpu_gbif.wen;
        cpu_gbif.rdata   = timed_out ? DEAD_BEEF : out_gbif.rdata;
        cpu_gbif.busy    = timed_out ? 1'b0 : out_gbif.busy;
      end
      DBG_XFER: begin
        out_gbif.addr    = dbg_gbif.addr;
        out_gbif.wdata   = dbg_gbif.wdata;
        out_gbif.byte_en = dbg_gbif.byte_en;
        out_gbif.wen     = dbg_gbif.wen;
        out_gbif.ren     = dbg_gbif.ren & ~dbg_gbif.wen;
        dbg_gbif.rdata   = timed_out ? DEAD_BEEF : out_gbif.rdata;
        dbg_gbif.busy    = timed_out ? 1'b0 : out_gbif.busy;
      end
      default: ;
    endcase
  end

  assign cpu_err = timed_out & (state_q == CPU_XFER) & ~RST;
  assign dbg_err = timed_out & (state_q == DBG_XFER) & ~RST;
  assign grant   = state_to_grant(state_q);

endmodule
